// File: rtl/stopwatch_core_if.sv
// Control pulses into the stopwatch and the BCD display/status signals out of it.
// The master drives the pulses; the slave (stopwatch_core) drives the display side.
interface stopwatch_core_if;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_hold;
    logic        overflow;

    modport master (
        output start_stop, lap, clear,
        input  disp_bcd, running, lap_hold, overflow
    );

    modport slave (
        input  start_stop, lap, clear,
        output disp_bcd, running, lap_hold, overflow
    );
endinterface

// File: rtl/stopwatch_core.sv
// BCD MM:SS.CC stopwatch counting synchronised usr_clk rising edges; count moves SYNC_STAGES+1
// clk edges after usr_clk is sampled high, display one edge later. No backpressure: pulses act on the edge that samples them.
module stopwatch_core #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_MAX     = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             usr_clk,
    stopwatch_core_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
        logic [3:0] cs_t;
        logic [3:0] cs_o;
    } bcd_t;

    localparam logic [3:0] MIN_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] MIN_O = 4'(MIN_MAX % 10);

    state_t                 state_q,    state_d;
    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic [SYNC_STAGES-1:0] fill_q,     fill_d;
    logic                   armed_q,    armed_d;
    logic                   prev_q,     prev_d;
    logic                   tick_q,     tick_d;
    bcd_t                   cnt_q,      cnt_d;
    bcd_t                   disp_q,     disp_d;
    logic                   running_q,  running_d;
    logic                   lap_hold_q, lap_hold_d;
    logic                   ovf_q,      ovf_d;

    logic                   sync_last;
    logic                   clear_take;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // The detector only arms after it has seen usr_clk low through a flushed
    // synchroniser, so a level already high at reset release is not a tick.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], usr_clk};
        fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
        armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~sync_last);
        prev_d  = sync_last;
        tick_d  = armed_q & sync_last & ~prev_q;
    end

    always_comb begin
        clear_take = bus.clear && (state_q != RUN);

        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.clear && bus.start_stop) state_d = RUN;
            RUN:     if (bus.start_stop)               state_d = PAUSE;
            PAUSE:   if (bus.clear)                    state_d = IDLE;
                     else if (bus.start_stop)          state_d = RUN;
            default: state_d = IDLE;
        endcase

        lap_hold_d = lap_hold_q;
        if (clear_take)
            lap_hold_d = 1'b0;
        else if (bus.lap && state_q == RUN)
            lap_hold_d = ~lap_hold_q;
        else if (bus.lap && state_q == PAUSE)
            lap_hold_d = 1'b0;

        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_take) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (tick_q && state_q == RUN) begin
            if (cnt_q.cs_o != 4'd9) begin
                cnt_d.cs_o = cnt_q.cs_o + 4'd1;
            end else begin
                cnt_d.cs_o = 4'd0;
                if (cnt_q.cs_t != 4'd9) begin
                    cnt_d.cs_t = cnt_q.cs_t + 4'd1;
                end else begin
                    cnt_d.cs_t = 4'd0;
                    if (cnt_q.sec_o != 4'd9) begin
                        cnt_d.sec_o = cnt_q.sec_o + 4'd1;
                    end else begin
                        cnt_d.sec_o = 4'd0;
                        if (cnt_q.sec_t != 4'd5) begin
                            cnt_d.sec_t = cnt_q.sec_t + 4'd1;
                        end else begin
                            cnt_d.sec_t = 4'd0;
                            if (cnt_q.min_t == MIN_T && cnt_q.min_o == MIN_O) begin
                                cnt_d = '0;
                                ovf_d = 1'b1;
                            end else if (cnt_q.min_o != 4'd9) begin
                                cnt_d.min_o = cnt_q.min_o + 4'd1;
                            end else begin
                                cnt_d.min_o = 4'd0;
                                cnt_d.min_t = cnt_q.min_t + 4'd1;
                            end
                        end
                    end
                end
            end
        end

        // Entering hold latches the post-update count so a same-cycle tick is included.
        if (lap_hold_d)
            disp_d = lap_hold_q ? disp_q : cnt_d;
        else
            disp_d = cnt_q;

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            fill_q     <= '0;
            armed_q    <= 1'b0;
            prev_q     <= 1'b0;
            tick_q     <= 1'b0;
            cnt_q      <= '0;
            disp_q     <= '0;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            fill_q     <= fill_d;
            armed_q    <= armed_d;
            prev_q     <= prev_d;
            tick_q     <= tick_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            running_q  <= running_d;
            lap_hold_q <= lap_hold_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.disp_bcd = disp_q;
    assign bus.running  = running_q;
    assign bus.lap_hold = lap_hold_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a table of control steps with expected display/status,
// followed by cycle-exact sequences for latency, same-cycle events and asynchronous reset.
module tb_stopwatch_core;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic usr_clk = 1'b0;

    stopwatch_core_if bus ();

    stopwatch_core #(.SYNC_STAGES(2), .MIN_MAX(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .usr_clk (usr_clk),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    typedef enum int {OP_SS, OP_LAP, OP_CLR, OP_TICK} op_t;
    typedef struct {
        op_t         op;
        int          n;
        logic [23:0] disp;
        logic        run;
        logic        hold;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [23:0] t(input int m, input int s, input int c);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic void add(input op_t op, input int n, input logic [23:0] d,
                                input logic r, input logic h, input logic o);
        vec_t v;
        v.op = op; v.n = n; v.disp = d; v.run = r; v.hold = h; v.ovf = o;
        vecs.push_back(v);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        usr_clk = 1'b1; cyc(); cyc();
        usr_clk = 1'b0; cyc(); cyc();
    endtask

    task automatic pulse(input op_t op);
        case (op)
            OP_SS:   bus.start_stop = 1'b1;
            OP_LAP:  bus.lap        = 1'b1;
            default: bus.clear      = 1'b1;
        endcase
        cyc();
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.clear      = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [23:0] d,
                             input logic r, input logic h, input logic o);
        check({tag, "_disp"}, bus.disp_bcd, d);
        check({tag, "_run"},  {23'd0, bus.running},  {23'd0, r});
        check({tag, "_hold"}, {23'd0, bus.lap_hold}, {23'd0, h});
        check({tag, "_ovf"},  {23'd0, bus.overflow}, {23'd0, o});
    endtask

    initial begin
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.clear      = 1'b0;

        add(OP_CLR,  0,    t(0,0,0),   0, 0, 0);
        add(OP_LAP,  0,    t(0,0,0),   0, 0, 0);
        add(OP_SS,   0,    t(0,0,0),   1, 0, 0);
        add(OP_TICK, 100,  t(0,1,0),   1, 0, 0);
        add(OP_SS,   0,    t(0,1,0),   0, 0, 0);
        add(OP_CLR,  0,    t(0,0,0),   0, 0, 0);
        add(OP_SS,   0,    t(0,0,0),   1, 0, 0);
        add(OP_TICK, 37,   t(0,0,37),  1, 0, 0);
        add(OP_LAP,  0,    t(0,0,37),  1, 1, 0);
        add(OP_TICK, 20,   t(0,0,37),  1, 1, 0);
        add(OP_LAP,  0,    t(0,0,57),  1, 0, 0);
        add(OP_SS,   0,    t(0,0,57),  0, 0, 0);
        add(OP_CLR,  0,    t(0,0,0),   0, 0, 0);
        add(OP_SS,   0,    t(0,0,0),   1, 0, 0);
        add(OP_TICK, 12,   t(0,0,12),  1, 0, 0);
        add(OP_SS,   0,    t(0,0,12),  0, 0, 0);
        add(OP_TICK, 10,   t(0,0,12),  0, 0, 0);
        add(OP_SS,   0,    t(0,0,12),  1, 0, 0);
        add(OP_CLR,  0,    t(0,0,12),  1, 0, 0);
        add(OP_SS,   0,    t(0,0,12),  0, 0, 0);
        add(OP_CLR,  0,    t(0,0,0),   0, 0, 0);
        add(OP_SS,   0,    t(0,0,0),   1, 0, 0);
        add(OP_TICK, 5999, t(0,59,99), 1, 0, 0);
        add(OP_TICK, 1,    t(1,0,0),   1, 0, 0);
        add(OP_TICK, 5999, t(1,59,99), 1, 0, 0);
        add(OP_TICK, 1,    t(0,0,0),   1, 0, 1);
        add(OP_TICK, 5,    t(0,0,5),   1, 0, 1);
        add(OP_LAP,  0,    t(0,0,5),   1, 1, 1);
        add(OP_SS,   0,    t(0,0,5),   0, 1, 1);
        add(OP_LAP,  0,    t(0,0,5),   0, 0, 1);
        add(OP_LAP,  0,    t(0,0,5),   0, 0, 1);
        add(OP_CLR,  0,    t(0,0,0),   0, 0, 0);

        repeat (3) cyc();
        check_all("reset", t(0,0,0), 0, 0, 0);
        reset = 1'b1;
        repeat (5) cyc();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].op == OP_TICK) begin
                for (int k = 0; k < vecs[i].n; k++) do_tick();
            end else begin
                pulse(vecs[i].op);
            end
            repeat (3) cyc();
            check_all($sformatf("v%0d", i), vecs[i].disp, vecs[i].run, vecs[i].hold, vecs[i].ovf);
        end

        // Tick latency: count moves on the 4th edge after sampling, display on the 5th.
        pulse(OP_SS);
        repeat (2) cyc();
        usr_clk = 1'b1; cyc(); cyc();
        usr_clk = 1'b0; cyc(); cyc();
        check("lat_edge4", bus.disp_bcd, t(0,0,0));
        cyc();
        check("lat_edge5", bus.disp_bcd, t(0,0,1));
        repeat (2) cyc();

        for (int k = 0; k < 7; k++) do_tick();
        repeat (2) cyc();
        check("pre_ss_tick", bus.disp_bcd, t(0,0,8));

        // start_stop lands on the same edge as the tick
        usr_clk = 1'b1; cyc(); cyc();
        usr_clk = 1'b0; cyc();
        bus.start_stop = 1'b1;
        cyc();
        bus.start_stop = 1'b0;
        repeat (2) cyc();
        check("ss_tick_disp", bus.disp_bcd, t(0,0,9));
        check("ss_tick_run", {23'd0, bus.running}, 24'd0);
        do_tick();
        repeat (2) cyc();
        check("pause_discard", bus.disp_bcd, t(0,0,9));

        bus.clear = 1'b1;
        bus.start_stop = 1'b1;
        cyc();
        bus.clear = 1'b0;
        bus.start_stop = 1'b0;
        repeat (2) cyc();
        check("clr_ss_run", {23'd0, bus.running}, 24'd0);
        check("clr_ss_disp", bus.disp_bcd, t(0,0,0));
        do_tick();
        repeat (2) cyc();
        check("idle_discard", bus.disp_bcd, t(0,0,0));

        // lap lands on the same edge as the tick
        pulse(OP_SS);
        cyc();
        usr_clk = 1'b1; cyc(); cyc();
        usr_clk = 1'b0; cyc();
        bus.lap = 1'b1;
        cyc();
        bus.lap = 1'b0;
        check("lap_tick_disp", bus.disp_bcd, t(0,0,1));
        check("lap_tick_hold", {23'd0, bus.lap_hold}, 24'd1);
        cyc();
        pulse(OP_LAP);
        repeat (2) cyc();

        for (int k = 0; k < 344; k++) do_tick();
        repeat (2) cyc();
        check("pre_reset", bus.disp_bcd, t(0,3,45));

        // Reset asserted and released between clock edges with usr_clk held high
        usr_clk = 1'b1;
        cyc();
        #3 reset = 1'b0;
        #1;
        check_all("arst", t(0,0,0), 0, 0, 0);
        #2 reset = 1'b1;
        bus.start_stop = 1'b1;
        cyc();
        bus.start_stop = 1'b0;
        repeat (10) cyc();
        check("post_rst_run", {23'd0, bus.running}, 24'd1);
        check("no_spurious", bus.disp_bcd, t(0,0,0));
        usr_clk = 1'b0;
        repeat (3) cyc();
        do_tick();
        repeat (2) cyc();
        check("fresh_edge", bus.disp_bcd, t(0,0,1));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Downstream consumer of the millisecond clock divider's `usr_clk` output.
- Each rising edge of `usr_clk` is one 10 ms tick: toggle every 250001 `clk` cycles, full period about 10 ms at 50 MHz.
- Counts ticks into a BCD stopwatch value MM:SS.CC, under start/stop, lap and clear control.
- Drives the BCD digit bus read by the seven-segment display scanner.

Parameters:
- SYNC_STAGES, 2: flip-flop stages used to synchronise `usr_clk` into the `clk` domain (minimum 2).
- MIN_MAX, 59: highest minutes value before wrap (BCD-decoded limit, must be ≤ 99).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- usr_clk  input  1  tick clock from the divider; asynchronous to `clk` logic, synchronised internally
- start_stop  input  1  single-cycle pulse, synchronous to `clk`; toggles run/pause
- lap  input  1  single-cycle pulse; toggles display freeze
- clear  input  1  single-cycle pulse; zeroes the count when not running
- disp_bcd  output  24  {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, each 4-bit BCD
- running  output  1  1 while the FSM is in RUN
- lap_hold  output  1  1 while the display is frozen
- overflow  output  1  sticky; set on wrap past MIN_MAX:59.99

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - FSM goes to IDLE.
  - All BCD counters, `disp_bcd`, `running`, `lap_hold` and `overflow` = 0.
  - Synchroniser flops = 0.
- Tick extraction:
  - `usr_clk` passes through SYNC_STAGES flops, then a rising-edge detector with a one-flop delay.
  - `tick` is a 1-cycle pulse.
  - The counter updates on the `clk` edge SYNC_STAGES+1 cycles after `usr_clk` is first sampled high.
  - Falling edges are ignored.
- Counter, advancing only when `tick`=1 and state = RUN:
  - cs_o 0–9; carry into cs_t 0–9.
  - At cs = 99, carry into sec_o 0–9, then sec_t 0–5.
  - At sec = 59, carry into minutes.
  - At MIN_MAX:59.99, the next tick → 00:00.00 and `overflow` ← 1; counting continues.
  - Digits never leave the BCD range.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start_stop → RUN.
  - RUN + start_stop → PAUSE.
  - PAUSE + start_stop → RUN.
  - PAUSE + clear → IDLE, with counters and `overflow` zeroed.
  - IDLE + clear → IDLE; counters and `overflow` re-zeroed.
  - RUN + clear → ignored.
- Simultaneous events:
  - `clear` and `start_stop` in the same cycle, state IDLE/PAUSE: `clear` wins, result IDLE, `start_stop` dropped.
  - `tick` and `start_stop` in the same cycle while in RUN: the tick is counted and the state becomes PAUSE.
  - `tick` while in IDLE or PAUSE: discarded, not queued.
- Lap:
  - While in RUN, `lap` toggles `lap_hold`.
  - On 0→1, `disp_bcd` captures the counter value as it stands after that cycle's update. It then stays frozen while counting continues internally.
  - On 1→0, `disp_bcd` tracks the live count again from the next cycle.
  - In PAUSE, `lap` only clears `lap_hold` and never sets it; in IDLE it is ignored.
  - A `clear` that takes effect forces `lap_hold` ← 0.
  - `lap` and `tick` in the same cycle: the captured value includes that tick.
- Output timing:
  - When `lap_hold`=0, `disp_bcd` is registered and equals the counter one cycle after the counter updates.
  - `running` is registered and equals (state == RUN).
- Asynchronous reset mid-run: immediate return to the reset values above; no tick is counted until a fresh rising edge of `usr_clk` after reset deasserts.

Test Plan:
1. Reset, start_stop pulse, 100 `usr_clk` rising edges → `disp_bcd` = 00:01.00, `running`=1; first increment appears SYNC_STAGES+1 cycles after the first edge.
2. Preload via 5999 ticks (00:59.99), then 1 tick → 01:00.00; from MIN_MAX:59.99, 1 tick → 00:00.00 with `overflow`=1.
3. Run 37 ticks, lap pulse, 20 more ticks → `disp_bcd` holds 00:00.37, `lap_hold`=1. Second lap pulse → display shows 00:00.57 next cycle.
4. Run to 00:00.12, start_stop → PAUSE; 10 ticks → display stays 00:00.12. `clear` in RUN is ignored; `clear` in PAUSE → 00:00.00, state IDLE, `overflow`=0.
5. Same-cycle tick + start_stop in RUN at 00:00.08 → 00:00.09 and PAUSE. Same-cycle clear + start_stop in PAUSE → IDLE with count 0.
6. Assert `reset` asynchronously (between `clk` edges) mid-run at 00:03.45 → all outputs 0 immediately. Deassert with `usr_clk` held high → no tick until `usr_clk` falls and rises again.
